ps2_scancode_rx: RTL and testbench

Upstream stage of the key-exchange entry FSM. It receives PS/2 keyboard frames on the raw PS2_CLK and PS2_DATA pins and checks framing and parity. It tracks make and break codes and presents the currently held make code on the 8-bit LED bus that the entry FSM decodes. When no key is held, LED reads 0x00; the FSM treats this as "no key" because 0x00 falls through to its default decode.

---
 rtl/ps2_scancode_rx.sv | 147 ++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, frames and checks 11-bit words, and
// tracks make/break codes to present the currently held key on LED.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] LED,
    output logic [7:0] RAW,
    output logic       CODE_STB,
    output logic       FRAME_ERR
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          fclk_q, fclk_prev_q;
    logic [FW-1:0] fcnt_q;
    logic          fall, dat;

    state_e        state_q, state_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          brk_q, brk_d;
    logic [7:0]    led_q, led_d, raw_q, raw_d;
    logic          stb_q, stb_d, err_q, err_d;

    // Bus idles high, so everything in the input path resets to 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q  <= {dat_sync_q[0], PS2_DATA};
            fclk_prev_q <= fclk_q;
            if (clk_sync_q[1] == fclk_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                fclk_q <= clk_sync_q[1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end

    assign fall = fclk_prev_q & ~fclk_q;
    assign dat  = dat_sync_q[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            bcnt_q  <= '0;
            shift_q <= '0;
            idle_q  <= '0;
            brk_q   <= 1'b0;
            led_q   <= '0;
            raw_q   <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            idle_q  <= idle_d;
            brk_q   <= brk_d;
            led_q   <= led_d;
            raw_q   <= raw_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        idle_d  = idle_q;
        brk_d   = brk_q;
        led_d   = led_q;
        raw_d   = raw_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                idle_d = '0;
                if (fall && !dat) begin
                    state_d = StRecv;
                    bcnt_d  = 4'd1;
                end
            end
            StRecv: begin
                if (fall) begin
                    shift_d = {dat, shift_q[9:1]};
                    bcnt_d  = bcnt_q + 4'd1;
                    idle_d  = '0;
                    if (bcnt_q == 4'd10) state_d = StDone;
                end else if (idle_q == TW'(TIMEOUT_CYC)) begin
                    state_d = StIdle;
                    bcnt_d  = '0;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                bcnt_d  = '0;
                // shift_q holds {stop, parity, data[7:0]}; odd parity over data+parity.
                if (!(^shift_q[8:0]) || !shift_q[9]) begin
                    err_d = 1'b1;
                end else begin
                    stb_d = 1'b1;
                    raw_d = shift_q[7:0];
                    if (shift_q[7:0] == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q[7:0] == 8'hE0) begin
                        brk_d = brk_q;
                    end else if (brk_q) begin
                        brk_d = 1'b0;
                        if (shift_q[7:0] == led_q) led_d = 8'h00;
                    end else begin
                        led_d = shift_q[7:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign LED       = led_q;
    assign RAW       = raw_q;
    assign CODE_STB  = stb_q;
    assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: table-driven make/break sequences, timeout, glitch and reset
// corner cases, then random frames checked against a byte-level held-key model.
module tb_ps2_scancode_rx;

    localparam int unsigned TO = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] led, raw;
    logic       code_stb, frame_err;

    ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .CLK      (clk),
        .RST      (rst),
        .PS2_CLK  (ps2_clk),
        .PS2_DATA (ps2_dat),
        .LED      (led),
        .RAW      (raw),
        .CODE_STB (code_stb),
        .FRAME_ERR(frame_err)
    );

    always #10 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int stb_cnt = 0, err_cnt = 0, stb0, err0;

    always @(negedge clk) begin
        if (code_stb === 1'b1) stb_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    // Byte-level model of the held-key rules.
    logic [7:0] m_led = 8'h00, m_raw = 8'h00;
    bit         m_brk = 1'b0;

    task automatic model(input logic [7:0] b, input bit good);
        if (good) begin
            m_raw = b;
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) begin
                if (m_brk) begin
                    m_brk = 1'b0;
                    if (b == m_led) m_led = 8'h00;
                end else m_led = b;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bp, input bit bs, input int half,
                        input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {~bs, (~^b) ^ bp, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            if (glitch) begin
                tick(5); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(half - 8);
            end else tick(half);
            ps2_clk = 1'b0;
            tick(half);
            ps2_clk = 1'b1;
        end
        tick(half);
        ps2_dat = 1'b1;
    endtask

    task automatic snap();
        stb0 = stb_cnt;
        err0 = err_cnt;
    endtask

    task automatic chk_out(input string name, input logic [7:0] el, input logic [7:0] er,
                           input int es, input int ee);
        @(negedge clk);
        chk({name, ".led"}, {24'h0, led}, {24'h0, el});
        chk({name, ".raw"}, {24'h0, raw}, {24'h0, er});
        chk({name, ".stb"}, stb_cnt - stb0, es);
        chk({name, ".err"}, err_cnt - err0, ee);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        logic [7:0] exp_led;
        logic [7:0] exp_raw;
        int         exp_stb;
        int         exp_err;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{8'hF0, 1'b0, 1'b0, 8'h16, 8'hF0, 1, 0};
        tbl[1]  = '{8'h16, 1'b0, 1'b0, 8'h00, 8'h16, 1, 0};
        tbl[2]  = '{8'h1C, 1'b1, 1'b0, 8'h00, 8'h16, 0, 1};
        tbl[3]  = '{8'h1C, 1'b0, 1'b1, 8'h00, 8'h16, 0, 1};
        tbl[4]  = '{8'h16, 1'b0, 1'b0, 8'h16, 8'h16, 1, 0};
        tbl[5]  = '{8'h1E, 1'b0, 1'b0, 8'h1E, 8'h1E, 1, 0};
        tbl[6]  = '{8'hF0, 1'b0, 1'b0, 8'h1E, 8'hF0, 1, 0};
        tbl[7]  = '{8'h16, 1'b0, 1'b0, 8'h1E, 8'h16, 1, 0};
        tbl[8]  = '{8'hE0, 1'b0, 1'b0, 8'h1E, 8'hE0, 1, 0};
        tbl[9]  = '{8'hF0, 1'b0, 1'b0, 8'h1E, 8'hF0, 1, 0};
        tbl[10] = '{8'h1E, 1'b0, 1'b0, 8'h00, 8'h1E, 1, 0};

        tick(5);
        rst = 1'b0;
        tick(2);
        snap();
        chk_out("reset", 8'h00, 8'h00, 0, 0);

        // 40 us bit period at 50 MHz.
        snap();
        send(8'h16, 1'b0, 1'b0, 1000, 1'b0, 11);
        tick(5);
        model(8'h16, 1'b1);
        chk_out("slow16", 8'h16, 8'h16, 1, 0);

        foreach (tbl[i]) begin
            snap();
            send(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, 25, 1'b0, 11);
            tick(5);
            model(tbl[i].code, !(tbl[i].bad_par || tbl[i].bad_stop));
            chk_out($sformatf("tbl%0d", i), tbl[i].exp_led, tbl[i].exp_raw,
                    tbl[i].exp_stb, tbl[i].exp_err);
        end

        // Partial frame abandoned by the keyboard must vanish silently.
        snap();
        send(8'h5A, 1'b0, 1'b0, 25, 1'b0, 5);
        tick(TO + 10);
        chk_out("timeout_gap", 8'h00, 8'h1E, 0, 0);
        snap();
        send(8'h32, 1'b0, 1'b0, 25, 1'b0, 11);
        tick(5);
        model(8'h32, 1'b1);
        chk_out("after_timeout", 8'h32, 8'h32, 1, 0);

        snap();
        send(8'h45, 1'b0, 1'b0, 30, 1'b1, 11);
        tick(5);
        model(8'h45, 1'b1);
        chk_out("glitch45", 8'h45, 8'h45, 1, 0);

        snap();
        send(8'h24, 1'b0, 1'b0, 25, 1'b0, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_led = 8'h00; m_raw = 8'h00; m_brk = 1'b0;
        chk_out("midreset", 8'h00, 8'h00, 0, 0);
        chk("midreset.stbpin", {31'h0, code_stb}, 32'h0);
        chk("midreset.errpin", {31'h0, frame_err}, 32'h0);
        tick(50);
        snap();
        send(8'h24, 1'b0, 1'b0, 25, 1'b0, 11);
        tick(5);
        model(8'h24, 1'b1);
        chk_out("post_reset24", 8'h24, 8'h24, 1, 0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] b;
            bit bp, bs;
            int sel, half;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: b = 8'hF0;
                1: b = 8'hE0;
                2, 3: begin
                    case ($urandom_range(0, 3))
                        0: b = 8'h16;
                        1: b = 8'h1E;
                        2: b = 8'h1C;
                        default: b = 8'h32;
                    endcase
                end
                default: b = 8'($urandom);
            endcase
            sel  = int'($urandom_range(0, 7));
            bp   = (sel == 0);
            bs   = (sel == 1);
            half = int'($urandom_range(20, 30));
            snap();
            send(b, bp, bs, half, 1'b0, 11);
            tick(5);
            model(b, !(bp || bs));
            chk_out($sformatf("rnd%0d_%02h", k, b), m_led, m_raw, (bp || bs) ? 0 : 1,
                    (bp || bs) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
